// File: rtl/micro_pkg.sv
// Shared definitions for the 8-bit micro control path: opcodes, FSM states,
// ALU select encodings and the decoded control word.
package micro_pkg;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_STA = 4'h2;
  localparam logic [3:0] OP_ADD = 4'h3;
  localparam logic [3:0] OP_SUB = 4'h4;
  localparam logic [3:0] OP_NOR = 4'h5;
  localparam logic [3:0] OP_SHL = 4'h6;
  localparam logic [3:0] OP_SHR = 4'h7;
  localparam logic [3:0] OP_CLR = 4'h8;
  localparam logic [3:0] OP_JMP = 4'h9;
  localparam logic [3:0] OP_JZ  = 4'hA;
  localparam logic [3:0] OP_JC  = 4'hB;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_MEMRD,
    S_MEMWR,
    S_EXEC,
    S_HALT
  } state_t;

  // ALU op select, shared with the ALU
  localparam logic [1:0] ALU_SHIFT = 2'b00;
  localparam logic [1:0] ALU_NOR   = 2'b01;
  localparam logic [1:0] ALU_ADD   = 2'b10;
  localparam logic [1:0] ALU_SUB   = 2'b11;

  // Sub-op select when ALU_SHIFT is selected
  localparam logic [1:0] LS_CLR = 2'b00;
  localparam logic [1:0] LS_SHL = 2'b01;
  localparam logic [1:0] LS_SHR = 2'b11;

  // Where DECODE sends the sequencer next
  typedef enum logic [2:0] {
    R_FETCH,
    R_JMP,
    R_JZ,
    R_JC,
    R_MEMRD,
    R_MEMWR,
    R_EXEC,
    R_HALT
  } route_t;

  typedef struct packed {
    route_t     route;
    logic [1:0] alu_sel;
    logic [1:0] load_shift;
    logic       acc_src;
    logic       upd_flags;
  } ctrl_word_t;

endpackage

// File: rtl/micro_decode.sv
// Combinational opcode-to-control-word decoder.
module micro_decode
  import micro_pkg::*;
(
  input  logic [3:0] opcode,
  output ctrl_word_t ctrl
);

  // Map each opcode onto its route and EXEC-cycle datapath selects
  always_comb begin
    ctrl.route      = R_FETCH;
    ctrl.alu_sel    = ALU_SHIFT;
    ctrl.load_shift = LS_CLR;
    ctrl.acc_src    = 1'b0;
    ctrl.upd_flags  = 1'b0;
    unique case (opcode)
      OP_LDA: begin ctrl.route = R_MEMRD; ctrl.acc_src = 1'b1; end
      OP_STA: ctrl.route = R_MEMWR;
      OP_ADD: begin ctrl.route = R_MEMRD; ctrl.alu_sel = ALU_ADD; ctrl.upd_flags = 1'b1; end
      OP_SUB: begin ctrl.route = R_MEMRD; ctrl.alu_sel = ALU_SUB; ctrl.upd_flags = 1'b1; end
      OP_NOR: begin ctrl.route = R_MEMRD; ctrl.alu_sel = ALU_NOR; ctrl.upd_flags = 1'b1; end
      OP_SHL: begin ctrl.route = R_EXEC; ctrl.load_shift = LS_SHL; ctrl.upd_flags = 1'b1; end
      OP_SHR: begin ctrl.route = R_EXEC; ctrl.load_shift = LS_SHR; ctrl.upd_flags = 1'b1; end
      OP_CLR: begin ctrl.route = R_EXEC; ctrl.load_shift = LS_CLR; ctrl.upd_flags = 1'b1; end
      OP_JMP: ctrl.route = R_JMP;
      OP_JZ:  ctrl.route = R_JZ;
      OP_JC:  ctrl.route = R_JC;
      OP_HLT: ctrl.route = R_HALT;
      default: ctrl.route = R_FETCH;
    endcase
  end

endmodule

// File: rtl/micro_control_unit.sv
// Multi-cycle sequencer for the 8-bit accumulator micro: fetch/decode/execute
// FSM, memory wait timeout and the architectural carry/zero flags.
module micro_control_unit
  import micro_pkg::*;
#(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] ir,
  input  logic       cout,
  input  logic       zout,
  input  logic       mem_rdy,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic       addr_sel,
  output logic       ir_load,
  output logic       pc_inc,
  output logic       pc_load,
  output logic       mdr_load,
  output logic       acc_load,
  output logic       acc_src,
  output logic [1:0] alu_sel,
  output logic [1:0] load_shift,
  output logic       c_flag,
  output logic       z_flag,
  output logic       halted,
  output logic       fault
);

  state_t     state, state_next;
  ctrl_word_t ctrl;
  logic [7:0] wait_cnt;
  logic       waiting;
  logic       timeout_hit;

  // The address field reaches memory through the datapath mux, not through here
  logic ir_addr_unused;
  assign ir_addr_unused = ^ir[3:0];

  micro_decode u_decode (
    .opcode (ir[7:4]),
    .ctrl   (ctrl)
  );

  assign waiting     = (state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR);
  assign timeout_hit = waiting && !mem_rdy && (wait_cnt == 8'(TIMEOUT - 1));

  // State register, wait counter, sticky fault and flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      wait_cnt <= '0;
      fault    <= 1'b0;
      c_flag   <= 1'b0;
      z_flag   <= 1'b0;
    end else begin
      state <= state_next;
      // Any state change clears the count, which covers entry to every wait state
      if (state_next != state)
        wait_cnt <= '0;
      else if (waiting && !mem_rdy)
        wait_cnt <= wait_cnt + 8'd1;
      if (timeout_hit)
        fault <= 1'b1;
      if (state == S_EXEC && ctrl.upd_flags) begin
        c_flag <= cout;
        z_flag <= zout;
      end
    end
  end

  // Next-state and output decode
  always_comb begin
    state_next = state;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    addr_sel   = 1'b0;
    ir_load    = 1'b0;
    pc_inc     = 1'b0;
    pc_load    = 1'b0;
    mdr_load   = 1'b0;
    acc_load   = 1'b0;
    acc_src    = 1'b0;
    alu_sel    = ALU_SHIFT;
    load_shift = LS_CLR;
    halted     = 1'b0;
    unique case (state)
      S_IDLE: state_next = S_FETCH;
      S_FETCH: begin
        mem_rd = 1'b1;
        if (mem_rdy) begin
          ir_load    = 1'b1;
          pc_inc     = 1'b1;
          state_next = S_DECODE;
        end else if (timeout_hit) begin
          state_next = S_HALT;
        end
      end
      S_DECODE: begin
        unique case (ctrl.route)
          R_JMP: begin pc_load = 1'b1;   state_next = S_FETCH; end
          R_JZ:  begin pc_load = z_flag; state_next = S_FETCH; end
          R_JC:  begin pc_load = c_flag; state_next = S_FETCH; end
          R_MEMRD: state_next = S_MEMRD;
          R_MEMWR: state_next = S_MEMWR;
          R_EXEC:  state_next = S_EXEC;
          R_HALT:  state_next = S_HALT;
          default: state_next = S_FETCH;
        endcase
      end
      S_MEMRD: begin
        mem_rd   = 1'b1;
        addr_sel = 1'b1;
        if (mem_rdy) begin
          mdr_load   = 1'b1;
          state_next = S_EXEC;
        end else if (timeout_hit) begin
          state_next = S_HALT;
        end
      end
      S_MEMWR: begin
        mem_wr   = 1'b1;
        addr_sel = 1'b1;
        if (mem_rdy)
          state_next = S_FETCH;
        else if (timeout_hit)
          state_next = S_HALT;
      end
      S_EXEC: begin
        acc_load   = 1'b1;
        acc_src    = ctrl.acc_src;
        alu_sel    = ctrl.alu_sel;
        load_shift = ctrl.load_shift;
        state_next = S_FETCH;
      end
      S_HALT: halted = 1'b1;
      default: state_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_micro_control_unit.sv
// Directed-vector bench for micro_control_unit: stimulus pushes the expected
// output word for every cycle; a negedge monitor pops and compares.
module tb_micro_control_unit;

  logic       clk = 1'b0;
  logic       rst_n, mem_rdy, cout, zout;
  logic [7:0] ir;
  logic       mem_rd, mem_wr, addr_sel, ir_load, pc_inc, pc_load, mdr_load;
  logic       acc_load, acc_src, c_flag, z_flag, halted, fault;
  logic [1:0] alu_sel, load_shift;

  micro_control_unit #(.TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .ir(ir), .cout(cout), .zout(zout), .mem_rdy(mem_rdy),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .addr_sel(addr_sel), .ir_load(ir_load),
    .pc_inc(pc_inc), .pc_load(pc_load), .mdr_load(mdr_load), .acc_load(acc_load),
    .acc_src(acc_src), .alu_sel(alu_sel), .load_shift(load_shift),
    .c_flag(c_flag), .z_flag(z_flag), .halted(halted), .fault(fault)
  );

  always #5 clk = ~clk;

  // Output word layout, msb first
  localparam logic [16:0] RD   = 17'h10000, WR   = 17'h08000, AS   = 17'h04000;
  localparam logic [16:0] IRL  = 17'h02000, PCI  = 17'h01000, PCL  = 17'h00800;
  localparam logic [16:0] MDR  = 17'h00400, ACCL = 17'h00200, SRC  = 17'h00100;
  localparam logic [16:0] AADD = 17'h00080, ASUB = 17'h000C0, ANOR = 17'h00040;
  localparam logic [16:0] LSHL = 17'h00010, LSHR = 17'h00030;
  localparam logic [16:0] CF   = 17'h00008, ZF   = 17'h00004;
  localparam logic [16:0] HLT  = 17'h00002, FLT  = 17'h00001;
  localparam logic [16:0] F    = RD | IRL | PCI;

  logic [16:0] act;
  assign act = {mem_rd, mem_wr, addr_sel, ir_load, pc_inc, pc_load, mdr_load, acc_load,
                acc_src, alu_sel, load_shift, c_flag, z_flag, halted, fault};

  typedef struct {
    logic [16:0] exp;
    string       name;
  } sb_t;

  sb_t sb[$];
  sb_t cur;
  int  n_vec = 0;
  int  n_err = 0;

  task automatic drive(input logic rst, input logic rdy, input logic [7:0] i,
                       input logic co, input logic zo, input logic [16:0] exp, input string nm);
    sb_t e;
    @(posedge clk);
    #1;
    rst_n = rst; mem_rdy = rdy; ir = i; cout = co; zout = zo;
    e.exp = exp; e.name = nm;
    sb.push_back(e);
  endtask

  task automatic s(input logic rdy, input logic [7:0] i, input logic [16:0] exp,
                   input string nm, input logic co = 1'b0, input logic zo = 1'b0);
    drive(1'b1, rdy, i, co, zo, exp, nm);
  endtask

  task automatic r(input string nm);
    drive(1'b0, 1'b1, 8'h00, 1'b0, 1'b0, '0, nm);
  endtask

  // Monitor: one expected word per cycle, compared mid-cycle
  always @(negedge clk) begin
    if (sb.size() != 0) begin
      cur = sb.pop_front();
      n_vec++;
      if (act !== cur.exp) begin
        n_err++;
        $display("FAIL %s: got %05h expected %05h", cur.name, act, cur.exp);
      end
    end
  end

  initial begin
    rst_n = 1'b0; mem_rdy = 1'b0; ir = 8'h00; cout = 1'b0; zout = 1'b0;
    r("reset");
    // JMP after reset release
    s(1, 8'h9A, '0,  "idle");
    s(1, 8'h9A, F,   "fetch_jmp");
    s(1, 8'h9A, PCL, "dec_jmp");
    // ADD sets carry
    s(1, 8'h35, F,             "fetch_add");
    s(1, 8'h35, '0,            "dec_add");
    s(1, 8'h35, RD | AS | MDR, "memrd_add");
    s(1, 8'h35, ACCL | AADD,   "exec_add", 1'b1, 1'b0);
    // JC taken, JZ not taken
    s(1, 8'hB3, F | CF,   "fetch_jc");
    s(1, 8'hB3, PCL | CF, "dec_jc");
    s(1, 8'hA3, F | CF,   "fetch_jz");
    s(1, 8'hA3, CF,       "dec_jz");
    // LDA with three memory wait cycles; flags untouched
    s(1, 8'h17, F | CF,  "fetch_lda");
    s(1, 8'h17, CF,      "dec_lda");
    for (int k = 0; k < 3; k++) s(0, 8'h17, RD | AS | CF, "memrd_wait");
    s(1, 8'h17, RD | AS | MDR | CF, "memrd_lda");
    s(1, 8'h17, ACCL | SRC | CF,    "exec_lda", 1'b0, 1'b1);
    // SUB then NOR
    s(1, 8'h48, F | CF,             "fetch_sub");
    s(1, 8'h48, CF,                 "dec_sub");
    s(1, 8'h48, RD | AS | MDR | CF, "memrd_sub");
    s(1, 8'h48, ACCL | ASUB | CF,   "exec_sub", 1'b0, 1'b1);
    s(1, 8'h59, F | ZF,             "fetch_nor");
    s(1, 8'h59, ZF,                 "dec_nor");
    s(1, 8'h59, RD | AS | MDR | ZF, "memrd_nor");
    s(1, 8'h59, ACCL | ANOR | ZF,   "exec_nor", 1'b1, 1'b0);
    // FETCH timeout after 4 wait cycles
    for (int k = 0; k < 4; k++) s(0, 8'h00, RD | CF, "fetch_wait");
    for (int k = 0; k < 3; k++) s(1, 8'h00, HLT | FLT | CF, "fault_halt");
    r("reset_fault");
    // Ready on the 4th wait cycle completes normally
    s(1, 8'h00, '0, "idle_b");
    for (int k = 0; k < 3; k++) s(0, 8'h00, RD, "fetch_wait_b");
    s(1, 8'h00, F,  "fetch_boundary");
    s(1, 8'h00, '0, "dec_nop");
    // SHL sets both flags, then STA interrupted by reset
    s(1, 8'h60, F,           "fetch_shl");
    s(1, 8'h60, '0,          "dec_shl");
    s(1, 8'h60, ACCL | LSHL, "exec_shl", 1'b1, 1'b1);
    s(1, 8'h25, F | CF | ZF,            "fetch_sta");
    s(1, 8'h25, CF | ZF,                "dec_sta");
    s(0, 8'h25, WR | AS | CF | ZF,      "memwr_sta");
    r("rst_memwr");
    s(1, 8'h25, '0, "idle_c");
    // Opcode D as NOP, SHR, CLR, then HLT
    s(1, 8'hD0, F,           "fetch_d");
    s(1, 8'hD0, '0,          "dec_d");
    s(1, 8'h70, F,           "fetch_shr");
    s(1, 8'h70, '0,          "dec_shr");
    s(1, 8'h70, ACCL | LSHR, "exec_shr", 1'b0, 1'b0);
    s(1, 8'h80, F,           "fetch_clr");
    s(1, 8'h80, '0,          "dec_clr");
    s(1, 8'h80, ACCL,        "exec_clr", 1'b0, 1'b1);
    s(1, 8'hF0, F | ZF,      "fetch_hlt");
    s(1, 8'hF0, ZF,          "dec_hlt");
    for (int k = 0; k < 22; k++) s(k[0], 8'hF0, HLT | ZF, "halt_hold", 1'b1, 1'b0);
    @(posedge clk);
    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL sb_drain: got %0d pending expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
